apple_ctrl: RTL and testbench

- Consumes the free-running random grid coordinates and turns them into a committed apple (food) position for the snake game.
- Rejects candidates that are off-grid, out of the playfield, on the snake head, or on the snake body. Body occupancy is checked through a request/acknowledge query to the snake body store.
- Detects when the head eats the apple, pulses an eat strobe, keeps the score, and places the next apple.
- Sits between the random coordinate generator and the snake/VGA drawing logic.

---
 rtl/snake_pkg.sv | 13 +
 rtl/apple_ctrl_if.sv | 11 +
 rtl/apple_cell_check.sv | 14 +
 rtl/apple_ctrl.sv | 129 ++++++++++++
 tb/tb_apple_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared grid constants, coordinate types and apple FSM states
package snake_pkg;
  localparam int CELL = 10;
  localparam int MIN_X = 20;
  localparam int MAX_X = 620;
  localparam int MIN_Y = 20;
  localparam int MAX_Y = 460;
  localparam int DEF_X = 320;
  localparam int DEF_Y = 240;
  typedef logic [9:0] coord_x_t;
  typedef logic [8:0] coord_y_t;
  typedef enum logic [1:0] {SAMPLE, QUERY, ARMED} apple_state_t;
endpackage

// File: rtl/apple_ctrl_if.sv
// apple_ctrl_if: body-occupancy query handshake between apple_ctrl and the snake body store
interface apple_ctrl_if;
  import snake_pkg::*;
  logic occ_req;
  coord_x_t occ_x;
  coord_y_t occ_y;
  logic occ_ack;
  logic occ_hit;
  modport master(output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
  modport slave(input occ_req, occ_x, occ_y, output occ_ack, occ_hit);
endinterface

// File: rtl/apple_cell_check.sv
// apple_cell_check: accepts a candidate cell that is grid-aligned, inside the playfield and off the head
module apple_cell_check import snake_pkg::*; (
  input  coord_x_t x,
  input  coord_y_t y,
  input  coord_x_t head_x,
  input  coord_y_t head_y,
  output logic     accept
);
  logic in_range, aligned, on_head;
  assign in_range = int'(x) >= MIN_X && int'(x) <= MAX_X && int'(y) >= MIN_Y && int'(y) <= MAX_Y;
  assign aligned = int'(x) % CELL == 0 && int'(y) % CELL == 0;
  assign on_head = x == head_x && y == head_y;
  assign accept = in_range && aligned && !on_head;
endmodule

// File: rtl/apple_ctrl.sv
// apple_ctrl: turns random grid coordinates into a committed apple, detects eating and keeps score
module apple_ctrl import snake_pkg::*; #(
  parameter int MAX_RETRY = 15,
  parameter int SCORE_W = 8
) (
  input  logic               VGA_clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               game_active,
  input  logic               new_game,
  input  coord_x_t           random_x,
  input  coord_y_t           random_y,
  input  coord_x_t           head_x,
  input  coord_y_t           head_y,
  apple_ctrl_if.master       occ,
  output coord_x_t           apple_x,
  output coord_y_t           apple_y,
  output logic               apple_valid,
  output logic               eat_pulse,
  output logic [SCORE_W-1:0] score,
  output logic               place_stall
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  apple_state_t state, state_n;
  logic req_q, req_n, pend_q, pend_n, valid_n, eat_n, stall_n;
  logic accept, eat_cond, retry_inc, retry_clr, stall_clr;
  coord_x_t qx_q, qx_n, ax_n;
  coord_y_t qy_q, qy_n, ay_n;
  logic [RW-1:0] retry_q, retry_n;
  logic [SCORE_W-1:0] score_n;
  apple_cell_check u_check (
    .x(random_x),
    .y(random_y),
    .head_x(head_x),
    .head_y(head_y),
    .accept(accept)
  );
  assign eat_cond = frame_tick && game_active && head_x == apple_x && head_y == apple_y;
  assign occ.occ_req = req_q;
  assign occ.occ_x = qx_q;
  assign occ.occ_y = qy_q;
  // next-state: sample, query the body store, hold the apple until eaten; new_game overrides
  always_comb begin
    state_n = state;
    req_n = req_q;
    qx_n = qx_q;
    qy_n = qy_q;
    ax_n = apple_x;
    ay_n = apple_y;
    valid_n = apple_valid;
    pend_n = pend_q;
    eat_n = 1'b0;
    retry_inc = 1'b0;
    retry_clr = new_game;
    stall_clr = new_game;
    unique case (state)
      SAMPLE: begin
        if (!new_game && accept) begin
          state_n = QUERY;
          req_n = 1'b1;
          qx_n = random_x;
          qy_n = random_y;
        end else if (!new_game) retry_inc = 1'b1;
      end
      QUERY: begin
        pend_n = pend_q || new_game;
        if (occ.occ_ack) begin
          state_n = SAMPLE;
          req_n = 1'b0;
          pend_n = 1'b0;
          if (!(pend_q || new_game)) begin
            if (occ.occ_hit) retry_inc = 1'b1;
            else begin
              state_n = ARMED;
              ax_n = qx_q;
              ay_n = qy_q;
              valid_n = 1'b1;
              retry_clr = 1'b1;
              stall_clr = 1'b1;
            end
          end
        end
      end
      ARMED: begin
        if (new_game || eat_cond) begin
          state_n = SAMPLE;
          valid_n = 1'b0;
          retry_clr = 1'b1;
          eat_n = !new_game;
        end
      end
      default: state_n = SAMPLE;
    endcase
    retry_n = retry_clr ? '0 : (retry_inc && retry_q != RETRY_MAX) ? retry_q + 1'b1 : retry_q;
    stall_n = !stall_clr && (place_stall || retry_n == RETRY_MAX);
    score_n = new_game ? '0 : (eat_n && !(&score)) ? score + 1'b1 : score;
  end
  // state and output registers; reset drops the query request immediately
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SAMPLE;
      req_q <= 1'b0;
      qx_q <= '0;
      qy_q <= '0;
      apple_x <= coord_x_t'(DEF_X);
      apple_y <= coord_y_t'(DEF_Y);
      apple_valid <= 1'b0;
      eat_pulse <= 1'b0;
      score <= '0;
      retry_q <= '0;
      place_stall <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= req_n;
      qx_q <= qx_n;
      qy_q <= qy_n;
      apple_x <= ax_n;
      apple_y <= ay_n;
      apple_valid <= valid_n;
      eat_pulse <= eat_n;
      score <= score_n;
      retry_q <= retry_n;
      place_stall <= stall_n;
      pend_q <= pend_n;
    end
  end
endmodule

// File: tb/tb_apple_ctrl.sv
// tb_apple_ctrl: directed and randomized checks of apple_ctrl against a rule-level model
module tb_apple_ctrl;
  logic VGA_clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0, game_active = 1'b0, new_game = 1'b0;
  logic [9:0] random_x = 10'd300, head_x = 10'd0, apple_x;
  logic [8:0] random_y = 9'd200, head_y = 9'd0, apple_y;
  logic apple_valid, eat_pulse, place_stall;
  logic [7:0] score;
  int checks = 0, errors = 0;
  int m_valid = 0, m_asking = 0, m_discard = 0, m_qx = 0, m_qy = 0, m_ax = 320, m_ay = 240;
  int m_eat = 0, m_score = 0, m_retry = 0, m_stall = 0;
  int ack_delay = 0, wait_cnt = 0, acks = 0;
  bit resp_rand = 1'b0;
  bit hit_q[$];
  apple_ctrl_if occ();
  apple_ctrl dut (
    .VGA_clk(VGA_clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .game_active(game_active),
    .new_game(new_game),
    .random_x(random_x),
    .random_y(random_y),
    .head_x(head_x),
    .head_y(head_y),
    .occ(occ),
    .apple_x(apple_x),
    .apple_y(apple_y),
    .apple_valid(apple_valid),
    .eat_pulse(eat_pulse),
    .score(score),
    .place_stall(place_stall)
  );
  always #5 VGA_clk = ~VGA_clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic bit legal(input int x, input int y, input int hx, input int hy);
    return x >= 20 && x <= 620 && y >= 20 && y <= 460 && x % 10 == 0 && y % 10 == 0 && !(x == hx && y == hy);
  endfunction
  // reference: apple placement rules applied once per clock from the inputs only
  always @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid = 0; m_asking = 0; m_discard = 0; m_qx = 0; m_qy = 0; m_ax = 320; m_ay = 240;
      m_eat = 0; m_score = 0; m_retry = 0; m_stall = 0;
    end else begin
      m_eat = 0;
      if (m_valid != 0) begin
        if (new_game) m_valid = 0;
        else if (frame_tick && game_active && int'(head_x) == m_ax && int'(head_y) == m_ay) begin
          m_eat = 1; m_valid = 0; m_retry = 0; m_score = (m_score == 255) ? 255 : m_score + 1;
        end
      end else if (m_asking != 0) begin
        if (occ.occ_ack) begin
          m_asking = 0;
          if (m_discard == 0 && !new_game) begin
            if (occ.occ_hit) m_retry++;
            else begin
              m_ax = m_qx; m_ay = m_qy; m_valid = 1; m_retry = 0; m_stall = 0;
            end
          end
          m_discard = 0;
        end else if (new_game) m_discard = 1;
      end else if (!new_game) begin
        if (legal(int'(random_x), int'(random_y), int'(head_x), int'(head_y))) begin
          m_asking = 1; m_qx = int'(random_x); m_qy = int'(random_y);
        end else m_retry++;
      end
      if (m_retry > 15) m_retry = 15;
      if (new_game) begin
        m_retry = 0; m_stall = 0; m_score = 0;
      end
      if (m_retry == 15) m_stall = 1;
    end
  end
  // compare every cycle on the falling edge
  always @(negedge VGA_clk) begin
    chk("occ_req", int'(occ.occ_req), m_asking);
    if (m_asking != 0) begin
      chk("occ_x", int'(occ.occ_x), m_qx);
      chk("occ_y", int'(occ.occ_y), m_qy);
    end
    chk("apple_valid", int'(apple_valid), m_valid);
    chk("apple_x", int'(apple_x), m_ax);
    chk("apple_y", int'(apple_y), m_ay);
    chk("eat_pulse", int'(eat_pulse), m_eat);
    chk("score", int'(score), m_score);
    chk("place_stall", int'(place_stall), m_stall);
  end
  // body-store responder: programmable ack delay and hit list, or fully random
  always @(negedge VGA_clk) begin
    if (resp_rand) begin
      wait_cnt = 0;
      occ.occ_ack = $urandom_range(0, 2) == 0;
      occ.occ_hit = $urandom_range(0, 3) == 0;
    end else begin
      wait_cnt = occ.occ_req ? wait_cnt + 1 : 0;
      occ.occ_ack = occ.occ_req && wait_cnt > ack_delay;
      occ.occ_hit = 1'b0;
      if (occ.occ_ack) begin
        acks++;
        if (hit_q.size() > 0) occ.occ_hit = hit_q.pop_front();
      end
    end
  end
  task automatic wait_valid(input int lim);
    int n = 0;
    do begin
      @(negedge VGA_clk);
      n++;
    end while (!apple_valid && n < lim);
    chk("wait_valid", int'(apple_valid), 1);
  endtask
  task automatic wait_req(input logic v, input int lim);
    int n = 0;
    do begin
      @(negedge VGA_clk);
      n++;
    end while (occ.occ_req != v && n < lim);
    chk("wait_req", int'(occ.occ_req), int'(v));
  endtask
  initial begin
    int rx[3] = '{625, 305, 100};
    int ry[3] = '{200, 200, 100};
    int cx, a0, n;
    occ.occ_ack = 1'b0;
    occ.occ_hit = 1'b0;
    repeat (3) @(negedge VGA_clk);
    chk("rst_valid", int'(apple_valid), 0);
    chk("rst_ax", int'(apple_x), 320);
    chk("rst_ay", int'(apple_y), 240);
    chk("rst_score", int'(score), 0);
    chk("rst_req", int'(occ.occ_req), 0);
    reset_n = 1'b1;
    @(negedge VGA_clk);
    chk("boot_req", int'(occ.occ_req), 1);
    chk("boot_valid0", int'(apple_valid), 0);
    @(negedge VGA_clk);
    chk("boot_valid", int'(apple_valid), 1);
    chk("boot_ax", int'(apple_x), 300);
    chk("boot_ay", int'(apple_y), 200);
    chk("boot_score", int'(score), 0);
    head_x = 10'd100; head_y = 9'd100;
    new_game = 1'b1; random_x = 10'd625; random_y = 9'd200;
    @(negedge VGA_clk);
    new_game = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) chk("stall_pre", int'(place_stall), 0);
      random_x = 10'(rx[i % 3]); random_y = 9'(ry[i % 3]);
      @(negedge VGA_clk);
    end
    chk("stall_set", int'(place_stall), 1);
    chk("stall_noreq", int'(occ.occ_req), 0);
    random_x = 10'd200; random_y = 9'd100;
    repeat (2) @(negedge VGA_clk);
    chk("stall_commit", int'(apple_valid), 1);
    chk("stall_clear", int'(place_stall), 0);
    chk("stall_ax", int'(apple_x), 200);
    ack_delay = 3; hit_q.push_back(1'b1);
    head_x = 10'd0; head_y = 9'd0;
    new_game = 1'b1; random_x = 10'd50; random_y = 9'd50;
    @(negedge VGA_clk);
    new_game = 1'b0;
    a0 = acks; n = 0;
    while (acks == a0 && n < 20) begin
      @(negedge VGA_clk);
      n++;
    end
    chk("hit_ack", acks - a0, 1);
    chk("hit_novalid", int'(apple_valid), 0);
    random_x = 10'd60; random_y = 9'd60;
    wait_valid(30);
    chk("delay_ax", int'(apple_x), 60);
    chk("delay_ay", int'(apple_y), 60);
    ack_delay = 0;
    head_x = 10'd60; head_y = 9'd60; random_x = 10'd70; random_y = 9'd60;
    game_active = 1'b0; frame_tick = 1'b1;
    @(negedge VGA_clk);
    frame_tick = 1'b0;
    chk("frozen_pulse", int'(eat_pulse), 0);
    chk("frozen_valid", int'(apple_valid), 1);
    chk("frozen_score", int'(score), 0);
    game_active = 1'b1; frame_tick = 1'b1;
    @(negedge VGA_clk);
    frame_tick = 1'b0;
    chk("eat_pulse1", int'(eat_pulse), 1);
    chk("eat_score1", int'(score), 1);
    chk("eat_valid0", int'(apple_valid), 0);
    @(negedge VGA_clk);
    chk("eat_once", int'(eat_pulse), 0);
    @(negedge VGA_clk);
    chk("next_valid", int'(apple_valid), 1);
    chk("next_ax", int'(apple_x), 70);
    cx = 70;
    repeat (254) begin
      head_x = 10'(cx); cx = (cx == 70) ? 80 : 70; random_x = 10'(cx); frame_tick = 1'b1;
      @(negedge VGA_clk);
      frame_tick = 1'b0;
      wait_valid(10);
    end
    chk("sat_reach", int'(score), 255);
    head_x = 10'(cx); cx = (cx == 70) ? 80 : 70; random_x = 10'(cx); frame_tick = 1'b1;
    @(negedge VGA_clk);
    frame_tick = 1'b0;
    chk("sat_pulse", int'(eat_pulse), 1);
    chk("sat_hold", int'(score), 255);
    wait_valid(10);
    head_x = 10'(cx); cx = (cx == 70) ? 80 : 70; random_x = 10'(cx); frame_tick = 1'b1; new_game = 1'b1;
    @(negedge VGA_clk);
    frame_tick = 1'b0; new_game = 1'b0;
    chk("ng_eat_pulse", int'(eat_pulse), 0);
    chk("ng_eat_score", int'(score), 0);
    chk("ng_eat_valid", int'(apple_valid), 0);
    ack_delay = 2;
    wait_req(1'b1, 5);
    new_game = 1'b1;
    @(negedge VGA_clk);
    new_game = 1'b0;
    wait_req(1'b0, 10);
    chk("ng_query_discard", int'(apple_valid), 0);
    wait_valid(20);
    new_game = 1'b1;
    @(negedge VGA_clk);
    new_game = 1'b0;
    wait_req(1'b1, 5);
    #2 reset_n = 1'b0;
    #1 chk("async_req", int'(occ.occ_req), 0);
    chk("async_valid", int'(apple_valid), 0);
    @(negedge VGA_clk);
    reset_n = 1'b1;
    wait_valid(20);
    resp_rand = 1'b1;
    repeat (3000) begin
      @(negedge VGA_clk);
      random_x = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'(10 * $urandom_range(0, 64));
      random_y = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'(10 * $urandom_range(0, 50));
      case ($urandom_range(0, 3))
        0, 1: begin head_x = 10'(m_ax); head_y = 9'(m_ay); end
        2: begin head_x = random_x; head_y = random_y; end
        default: begin head_x = 10'(10 * $urandom_range(0, 64)); head_y = 9'(10 * $urandom_range(0, 50)); end
      endcase
      frame_tick = $urandom_range(0, 3) == 0;
      game_active = $urandom_range(0, 7) != 0;
      new_game = $urandom_range(0, 59) == 0;
    end
    @(negedge VGA_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
